// File: rtl/bus_pkg.sv
// Shared types for the multiplexed CPU bus frame decoder.
// Bus byte width, phase codes, request FSM states, control bit indices.
package bus_pkg;

    localparam int BUS_W  = 8;
    localparam int ADDR_W = 16;

    localparam int RW_BIT   = 0;
    localparam int SYNC_BIT = 1;

    typedef enum logic [1:0] {
        PH_LO  = 2'd0,
        PH_HI  = 2'd1,
        PH_CTL = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bus_frame_sampler.sv
// Phase counter and lo/hi/ctl capture for the multiplexed bus stream.
// Pulses frame_valid the cycle after each committed phase-0 sample.
module bus_frame_sampler
    import bus_pkg::*;
#(
    parameter int DATA_W = bus_pkg::BUS_W,
    parameter int ADDR_W = bus_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic              frame_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic              sync
);

    logic [1:0]        ph;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic              first_frame;

    // bus_in lags the producer by one clk, so the byte of phase p
    // is captured while the counter already reads p+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph          <= PH_LO;
            lo          <= '0;
            hi          <= '0;
            addr        <= '0;
            rw          <= 1'b0;
            sync        <= 1'b0;
            first_frame <= 1'b1;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (ph)
                PH_LO: begin
                    ph <= PH_HI;
                    if (first_frame) begin
                        first_frame <= 1'b0;
                    end else begin
                        rw          <= bus_in[RW_BIT];
                        sync        <= bus_in[SYNC_BIT];
                        addr        <= {hi, lo};
                        frame_valid <= 1'b1;
                    end
                end
                PH_HI: begin
                    ph <= PH_CTL;
                    lo <= bus_in;
                end
                PH_CTL: begin
                    ph <= PH_LO;
                    hi <= bus_in;
                end
                default: ph <= PH_LO;
            endcase
        end
    end

endmodule

// File: rtl/bus_frame_decoder.sv
// Rebuilds CPU bus frames and runs a req/ack transaction per frame.
// Optional duplicate-frame suppression: BUS_FRAME_DEDUP_EN.
module bus_frame_decoder
    import bus_pkg::*;
#(
    parameter int ADDR_W      = bus_pkg::ADDR_W,
    parameter int DATA_W      = bus_pkg::BUS_W,
    parameter int ACK_TIMEOUT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic [DATA_W-1:0] cpu_oe,
    output logic [DATA_W-1:0] cpu_din,
    output logic              frame_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic              sync,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              overrun
);

    localparam int WD_W = $clog2(ACK_TIMEOUT + 1) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [WD_W-1:0]   wd;
    logic [DATA_W-1:0] rdata_q;
    logic              fwd;
    logic              accept;
    logic              timeout;

    bus_frame_sampler #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .frame_valid(frame_valid),
        .addr       (addr),
        .rw         (rw),
        .sync       (sync)
    );

`ifdef BUS_FRAME_DEDUP_EN
    logic [ADDR_W+1:0] last;
    logic              dup;

    // A write carrying new data is always forwarded.
    assign dup = ({addr, rw, sync} == last)
               && !(!rw && (cpu_dout != mem_wdata));
    assign fwd = frame_valid && !dup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '0;
        end else if (accept) begin
            last <= {addr, rw, sync};
        end
    end
`else
    assign fwd = frame_valid;
`endif

    assign accept  = fwd && (state == IDLE);
    assign timeout = (wd == WD_W'(ACK_TIMEOUT));
    assign mem_req = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (fwd) state_nxt = REQ;
            REQ: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd        <= WD_W'(1);
            rdata_q   <= '0;
            cpu_din   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr <= addr;
                mem_we   <= ~rw;
                if (&cpu_oe) begin
                    mem_wdata <= cpu_dout;
                end
            end
            // Watchdog reads 1 on the first REQ cycle.
            wd <= (state == REQ) ? wd + WD_W'(1) : WD_W'(1);
            if (state == REQ && mem_ack) begin
                rdata_q <= mem_rdata;
            end
            if (state == RESP && !mem_we) begin
                cpu_din <= rdata_q;
            end
            if ((fwd && state != IDLE)
                || (state == REQ && !mem_ack && timeout)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
